// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the operand loader front end of the logic ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_SHR = 3'd3,
        OP_SHL = 3'd4
    } opcode_t;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        ISSUE   = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int OP_LEGAL_MAX = 4;

endpackage

// File: rtl/btn_edge.sv
// Synchronizes the raw load button and emits a single-cycle pulse per press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic btn_p0, btn_p1, btn_p2;
    logic rdy_p0, rdy_p1;
    logic armed;

    // armed stays low until the synchronized button has been seen released,
    // so a button held through reset cannot fire a spurious press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
            btn_p2 <= 1'b0;
            rdy_p0 <= 1'b0;
            rdy_p1 <= 1'b0;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
            rdy_p0 <= 1'b1;
            rdy_p1 <= rdy_p0;
            if (rdy_p1 && !btn_p1)
                armed <= 1'b1;
            pulse  <= armed && btn_p1 && !btn_p2;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Button-driven loader that collects A, B and an opcode, then issues them to the logic ALU.
module operand_loader
    import alu_pkg::*;
#(
    parameter int N   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   sw,
    input  logic [OPW-1:0] op_sw,
    input  logic           btn,
    input  logic           clear,
    input  logic           ack,
    output logic [N-1:0]   A,
    output logic [N-1:0]   B,
    output logic [OPW-1:0] op,
    output logic           valid,
    output logic           err,
    output logic [2:0]     state
);

    logic   pulse;
    logic   ld_a, ld_b, ld_op;
    logic   op_legal;
    state_t state_q, state_d;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .pulse (pulse)
    );

    assign op_legal = (op_sw <= OPW'(OP_LEGAL_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= LOAD_A;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        if (clear) begin
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: if (pulse) begin
                    ld_a    = 1'b1;
                    state_d = LOAD_B;
                end
                LOAD_B: if (pulse) begin
                    ld_b    = 1'b1;
                    state_d = LOAD_OP;
                end
                LOAD_OP: if (pulse) begin
                    ld_op   = 1'b1;
                    state_d = op_legal ? ISSUE : ERR;
                end
                ISSUE: if (ack) state_d = LOAD_A;
                ERR:   if (pulse) state_d = LOAD_OP;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A  <= '0;
            B  <= '0;
            op <= '0;
        end else if (clear) begin
            A  <= '0;
            B  <= '0;
            op <= '0;
        end else begin
            if (ld_a)  A  <= sw;
            if (ld_b)  B  <= sw;
            if (ld_op) op <= op_sw;
        end
    end

    // Moore outputs straight from the state register, so reset drops them immediately.
    assign valid = (state_q == ISSUE);
    assign err   = (state_q == ERR);
    assign state = state_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits.
REQ-002 SHALL have parameter OPW, default 3, opcode width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sw  input  N  operand value from switches.
REQ-006 op_sw  input  OPW  opcode value from switches.
REQ-007 btn  input  1  raw load pushbutton, asynchronous to clk, active-high.
REQ-008 clear  input  1  synchronous abort, active-high.
REQ-009 ack  input  1  downstream logic ALU accepted the operand set.
REQ-010 A  output  N  registered operand A to the logic ALU.
REQ-011 B  output  N  registered operand B (also the shift amount).
REQ-012 op  output  OPW  registered opcode.
REQ-013 valid  output  1  A/B/op form a complete, stable set.
REQ-014 err  output  1  captured opcode is outside the legal set.
REQ-015 state  output  3  current FSM state encoding, for LEDs.

Function
REQ-016 Opcodes SHALL be 0 AND, 1 OR, 2 XOR, 3 SHR, 4 SHL; values 5..7 are illegal.
REQ-017 btn SHALL pass a 2-flop synchronizer and then a rising-edge detector, giving a 1-cycle press pulse.
REQ-018 Press pulse SHALL occur 3 cycles after btn rises; a held btn SHALL produce exactly one pulse.
REQ-019 FSM states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, ISSUE=3, ERR=4.
REQ-020 LOAD_A + pulse: A<=sw, go LOAD_B.
REQ-021 LOAD_B + pulse: B<=sw, go LOAD_OP.
REQ-022 LOAD_OP + pulse: op<=op_sw; legal opcode -> ISSUE, illegal -> ERR.
REQ-023 ISSUE: valid=1; ack -> LOAD_A next cycle, with A, B and op held unchanged.
REQ-024 In ISSUE, press pulses SHALL be ignored; valid SHALL stay high until ack.
REQ-025 ERR: err=1 and valid=0; a press pulse returns to LOAD_OP with op unchanged.
REQ-026 valid and err SHALL be Moore outputs, never both high.
REQ-027 A, B and op SHALL change only on their own load event, never while valid=1.
REQ-028 clear SHALL have priority over pulse and ack: next state LOAD_A, and A, B, op, valid, err all 0.
REQ-029 ack outside ISSUE SHALL be ignored.
REQ-030 Any illegal state encoding SHALL recover to LOAD_A on the next cycle.

Reset
REQ-031 rst SHALL immediately force state=LOAD_A, A=0, B=0, op=0, valid=0, err=0 and clear the synchronizer/edge flops.
REQ-032 rst asserted mid-ISSUE SHALL drop valid asynchronously, without waiting for ack.
REQ-033 After rst deasserts, a btn already held high SHALL NOT generate a pulse until it is released and pressed again.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode enum (OP_AND..OP_SHL), the FSM state enum, and the OP_LEGAL_MAX=4 constant.
REQ-035 Sub-module btn_edge SHALL contain the synchronizer and edge detector; the top-level module holds the FSM and registers.

Verification
REQ-036 Happy path, N=4: sw=0x5 press, sw=0x3 press, op_sw=2 press -> A=5, B=3, op=2, valid=1; ack -> LOAD_A, valid=0.
REQ-037 btn held 20 cycles in LOAD_A -> exactly one advance, to LOAD_B.
REQ-038 op_sw=6 in LOAD_OP -> ERR, err=1; op_sw=4 plus press -> op still 6, state LOAD_OP; press -> op=4, ISSUE.
REQ-039 In ISSUE, press without ack for 10 cycles -> valid stays 1 and A/B/op unchanged.
REQ-040 clear and pulse in the same cycle in LOAD_B -> LOAD_A with all outputs 0; rst mid-ISSUE -> valid=0 with no clock edge.
